gpio_serial_rx_fifo: RTL and testbench

Receive-direction counterpart of the GPIO serial transmit path. It samples the `gpio_in` pin once per `rclk` cycle, deframes start/data/stop bits into `DSIZE`-bit words, and buffers the words in a synchronous FIFO that a host drains with `rinc`. It sits between the GPIO pad and the host-side read logic in the `rclk` domain. The last good word is mirrored on `pin_status`.

---
 rtl/gpio_serial_rx_fifo.sv | 108 ++++++++++
 tb/tb_gpio_serial_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_rx_fifo.sv
// GPIO serial receiver: start/data/stop deframer feeding a show-ahead FIFO.
// The last good word is mirrored on pin_status; overrun is sticky until reset.
module gpio_serial_rx_fifo #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             gpio_direction,
   input  logic             gpio_in,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             rfull,
   output logic [ASIZE:0]   rcount,
   output logic [DSIZE-1:0] pin_status,
   output logic             frame_err,
   output logic             overrun
);

   localparam int CW    = $clog2(DSIZE + 1);
   localparam int DEPTH = 1 << ASIZE;

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [DSIZE-1:0] shreg;
   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic [DSIZE-1:0] mem [DEPTH];
   logic             good;
   logic             bad;
   logic             pop;
   logic             push;

   assign good   = (state == STOP) && !gpio_direction && gpio_in;
   assign bad    = (state == STOP) && !gpio_direction && !gpio_in;
   assign rempty = (wptr == rptr);
   assign rfull  = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) &&
                   (wptr[ASIZE] != rptr[ASIZE]);
   assign pop    = rinc && !rempty;
   assign push   = good && (!rfull || pop);
   assign rcount = wptr - rptr;
   assign rdata  = mem[rptr[ASIZE-1:0]];

   // Deframer FSM with registered status outputs.
   // Bits shift in from the top so the first (LSB) bit lands in bit 0.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         pin_status <= '0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= bad;
         if (gpio_direction) begin
            state   <= IDLE;
            bit_cnt <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (!gpio_in) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {gpio_in, shreg[DSIZE-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == CW'(DSIZE - 1))
                     state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (gpio_in) begin
                     pin_status <= shreg;
                     if (rfull && !pop)
                        overrun <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // FIFO storage and pointers; a pop on a full FIFO frees the slot
   // that the same-cycle push then reuses.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wptr[ASIZE-1:0]] <= shreg;
            wptr <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: tb/tb_gpio_serial_rx_fifo.sv
// Directed bench for gpio_serial_rx_fifo: frame table plus
// hand sequences for reset, abort, overrun and full-with-pop.
module tb_gpio_serial_rx_fifo;

   logic       rclk;
   logic       rrst_n;
   logic       gpio_direction;
   logic       gpio_in;
   logic       rinc;
   logic [7:0] rdata;
   logic       rempty;
   logic       rfull;
   logic [4:0] rcount;
   logic [7:0] pin_status;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   gpio_serial_rx_fifo #(.DSIZE(8), .ASIZE(4)) dut (
      .rclk           (rclk),
      .rrst_n         (rrst_n),
      .gpio_direction (gpio_direction),
      .gpio_in        (gpio_in),
      .rinc           (rinc),
      .rdata          (rdata),
      .rempty         (rempty),
      .rfull          (rfull),
      .rcount         (rcount),
      .pin_status     (pin_status),
      .frame_err      (frame_err),
      .overrun        (overrun)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       pop;
      logic       empty;
      logic [7:0] rdata;
      logic [7:0] pin;
      int         count;
      logic       ferr;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one frame, one bit per negedge; returns one negedge after the
   // stop-bit edge with the line back at idle. pop_stop asserts rinc
   // during the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic pop_stop);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         gpio_in = bits[i];
         rinc    = (i == 9) ? pop_stop : 1'b0;
         @(negedge rclk);
      end
      gpio_in = 1'b1;
      rinc    = 1'b0;
   endtask

   task automatic pop_one();
      rinc = 1'b1;
      @(negedge rclk);
      rinc = 1'b0;
   endtask

   task automatic do_reset();
      gpio_in = 1'b1;
      rinc    = 1'b0;
      rrst_n  = 1'b0;
      @(negedge rclk);
      @(negedge rclk);
      rrst_n  = 1'b1;
      @(negedge rclk);
   endtask

   initial begin
      int fe_seen;

      tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 8'hA5, 1, 1'b0};
      tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 0, 1'b1};
      tbl[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 1, 1'b0};
      tbl[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'h5A, 8'hC3, 2, 1'b0};
      tbl[4] = '{8'h0F, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h0F, 2, 1'b0};

      gpio_direction = 1'b0;
      gpio_in        = 1'b1;
      rinc           = 1'b0;
      rrst_n         = 1'b0;
      @(negedge rclk);
      @(negedge rclk);

      chk("rst_rempty", rempty, 1);
      chk("rst_rfull", rfull, 0);
      chk("rst_rcount", rcount, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_pin", pin_status, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      rrst_n = 1'b1;
      @(negedge rclk);

      foreach (tbl[k]) begin
         send_frame(tbl[k].data, tbl[k].stop, 1'b0);
         chk($sformatf("v%0d_empty", k), rempty, tbl[k].empty);
         if (!tbl[k].empty)
            chk($sformatf("v%0d_rdata", k), rdata, tbl[k].rdata);
         chk($sformatf("v%0d_pin", k), pin_status, tbl[k].pin);
         chk($sformatf("v%0d_count", k), rcount, tbl[k].count);
         chk($sformatf("v%0d_ferr", k), frame_err, tbl[k].ferr);
         @(negedge rclk);
         chk($sformatf("v%0d_ferr_drop", k), frame_err, 0);
         if (tbl[k].pop) begin
            pop_one();
            chk($sformatf("v%0d_popcnt", k), rcount, tbl[k].count - 1);
         end
      end

      chk("tail_head0", rdata, 8'hC3);
      pop_one();
      chk("tail_head1", rdata, 8'h0F);
      pop_one();
      chk("tail_empty", rempty, 1);

      // Direction abort after four data bits.
      fe_seen = 0;
      gpio_in = 1'b0;
      @(negedge rclk);
      for (int i = 0; i < 4; i++) begin
         gpio_in = i[0];
         @(negedge rclk);
      end
      gpio_direction = 1'b1;
      gpio_in        = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge rclk);
         if (frame_err) fe_seen++;
      end
      gpio_direction = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge rclk);
         if (frame_err) fe_seen++;
      end
      chk("abort_empty", rempty, 1);
      chk("abort_ferr", fe_seen, 0);
      chk("abort_pin", pin_status, 8'h0F);
      send_frame(8'hC3, 1'b1, 1'b0);
      chk("abort_next_rdata", rdata, 8'hC3);
      chk("abort_next_cnt", rcount, 1);

      // Mid-frame reset clears stored words and the partial frame.
      gpio_in = 1'b0;
      @(negedge rclk);
      gpio_in = 1'b1;
      @(negedge rclk);
      do_reset();
      chk("midrst_empty", rempty, 1);
      chk("midrst_pin", pin_status, 0);
      repeat (12) @(negedge rclk);
      chk("midrst_idle", rcount, 0);

      // Fill, then one dropped frame.
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1, 1'b0);
         if (i == 15) begin
            chk("fill_full", rfull, 1);
            chk("fill_cnt", rcount, 16);
            chk("fill_ovr0", overrun, 0);
         end
      end
      chk("ovr_set", overrun, 1);
      chk("ovr_pin", pin_status, 8'h10);
      chk("ovr_cnt", rcount, 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d", i), rdata, i);
         pop_one();
      end
      chk("drain_empty", rempty, 1);
      chk("ovr_sticky", overrun, 1);

      // Full with a pop on the stop-bit edge.
      do_reset();
      for (int i = 0; i < 16; i++)
         send_frame(8'(i), 1'b1, 1'b0);
      chk("fp_full", rfull, 1);
      send_frame(8'h77, 1'b1, 1'b1);
      chk("fp_cnt", rcount, 16);
      chk("fp_ovr", overrun, 0);
      chk("fp_head", rdata, 1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("fp_pop%0d", i), rdata, (i == 15) ? 8'h77 : i + 1);
         pop_one();
      end
      chk("fp_empty", rempty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
